// File: rtl/i2c_regmap_arbiter.sv
// Round-robin arbiter sharing one single-port 8-bit register RAM between two I2C slave ports (A=BMC, B=host).
// Define I2C_ARB_WP_EN to block port-B writes to WP_LO..WP_HI (flagged on o_wp_err, still acked).
module i2c_regmap_arbiter #(
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [ADDR_W-1:0] WP_LO  = ADDR_W'(8'hF0),
  parameter logic [ADDR_W-1:0] WP_HI  = ADDR_W'(8'hFF)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [7:0]        i_a_wdata,
  output logic              o_a_ack,
  output logic [7:0]        o_a_rdata,
  output logic              o_a_ovf,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [7:0]        i_b_wdata,
  output logic              o_b_ack,
  output logic [7:0]        o_b_rdata,
  output logic              o_b_ovf,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata,
  output logic              o_wp_err
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_ACK} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef I2C_ARB_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t            r_state;
  logic              r_a_pend, r_a_busy, r_a_we;
  logic [ADDR_W-1:0] r_a_addr;
  logic [7:0]        r_a_wdata;
  logic              r_b_pend, r_b_busy, r_b_we;
  logic [ADDR_W-1:0] r_b_addr;
  logic [7:0]        r_b_wdata;
  logic              r_ptr_b, r_gnt_b, r_rd, r_oor;

  logic              w_a_free, w_b_free, w_pick_b;
  logic              w_cur_we, w_oor, w_wp;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [7:0]        w_cur_wdata;

  // A port stays busy from capture until its ack; the ack cycle itself frees it.
  assign w_a_free = !r_a_pend && (!r_a_busy || (r_state == S_ACK && !r_gnt_b));
  assign w_b_free = !r_b_pend && (!r_b_busy || (r_state == S_ACK && r_gnt_b));
  assign w_pick_b = r_b_pend && (!r_a_pend || r_ptr_b);

  assign w_cur_we    = r_gnt_b ? r_b_we    : r_a_we;
  assign w_cur_addr  = r_gnt_b ? r_b_addr  : r_a_addr;
  assign w_cur_wdata = r_gnt_b ? r_b_wdata : r_a_wdata;
  assign w_oor       = {1'b0, w_cur_addr} >= DEPTH_L;
  assign w_wp        = WP_EN && r_gnt_b && w_cur_we && (w_cur_addr >= WP_LO) && (w_cur_addr <= WP_HI);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_a_pend    <= 1'b0;
      r_a_busy    <= 1'b0;
      r_a_we      <= 1'b0;
      r_a_addr    <= '0;
      r_a_wdata   <= 8'h00;
      r_b_pend    <= 1'b0;
      r_b_busy    <= 1'b0;
      r_b_we      <= 1'b0;
      r_b_addr    <= '0;
      r_b_wdata   <= 8'h00;
      r_ptr_b     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_rd        <= 1'b0;
      r_oor       <= 1'b0;
      o_a_ack     <= 1'b0;
      o_a_rdata   <= 8'h00;
      o_a_ovf     <= 1'b0;
      o_b_ack     <= 1'b0;
      o_b_rdata   <= 8'h00;
      o_b_ovf     <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= 8'h00;
      o_wp_err    <= 1'b0;
    end else begin
      o_a_ack  <= 1'b0;
      o_b_ack  <= 1'b0;
      o_ram_en <= 1'b0;
      o_ram_we <= 1'b0;
      o_wp_err <= 1'b0;

      if (i_a_req) begin
        if (w_a_free) begin
          r_a_pend  <= 1'b1;
          r_a_we    <= i_a_we;
          r_a_addr  <= i_a_addr;
          r_a_wdata <= i_a_wdata;
        end else begin
          o_a_ovf <= 1'b1;
        end
      end
      if (i_b_req) begin
        if (w_b_free) begin
          r_b_pend  <= 1'b1;
          r_b_we    <= i_b_we;
          r_b_addr  <= i_b_addr;
          r_b_wdata <= i_b_wdata;
        end else begin
          o_b_ovf <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_a_pend || r_b_pend) begin
            r_gnt_b <= w_pick_b;
            r_ptr_b <= !w_pick_b;
            if (w_pick_b) begin
              r_b_pend <= 1'b0;
              r_b_busy <= 1'b1;
            end else begin
              r_a_pend <= 1'b0;
              r_a_busy <= 1'b1;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          o_ram_en    <= !w_oor && !w_wp;
          o_ram_we    <= w_cur_we && !w_oor && !w_wp;
          o_ram_addr  <= w_cur_addr;
          o_ram_wdata <= w_cur_wdata;
          o_wp_err    <= w_wp;
          r_rd        <= !w_cur_we;
          r_oor       <= w_oor;
          r_state     <= w_cur_we ? S_ACK : S_RDWAIT;
        end
        S_RDWAIT: r_state <= S_ACK;
        S_ACK: begin
          // RAM data is valid here, one clock after the strobe dropped.
          if (r_gnt_b) begin
            o_b_ack  <= 1'b1;
            r_b_busy <= 1'b0;
            if (r_rd) o_b_rdata <= r_oor ? 8'hFF : i_ram_rdata;
          end else begin
            o_a_ack  <= 1'b1;
            r_a_busy <= 1'b0;
            if (r_rd) o_a_rdata <= r_oor ? 8'hFF : i_ram_rdata;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_regmap_arbiter.sv
// Scoreboard bench for i2c_regmap_arbiter: expected acks queued per port at request time, checked on ack.
module tb_i2c_regmap_arbiter;
  localparam int         DEPTH_T = 128;
  localparam logic [7:0] WP_LO_T = 8'h70;
  localparam logic [7:0] WP_HI_T = 8'h7F;
`ifdef I2C_ARB_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef struct {
    logic       we;
    logic [7:0] exp;
    int         t;
    int         lat;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, b_addr = 8'h00, b_wdata = 8'h00;
  logic       a_ack, a_ovf, b_ack, b_ovf, ram_en, ram_we, wp_err;
  logic [7:0] a_rdata, b_rdata, ram_addr, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;

  logic [7:0] mem [256];
  logic [7:0] mdl [256];
  sb_t        qa[$];
  sb_t        qb[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ra = 0, rb = 0;
  int a_n = 0, b_n = 0, rl_n = 0, wp_n = 0;
  logic [7:0] a_d [64];
  logic [7:0] b_d [64];
  int         a_t [64];
  int         b_t [64];
  int         rl_t [64];
  logic       rl_we [64];
  logic [7:0] rl_ad [64];
  logic [7:0] rl_wd [64];

  i2c_regmap_arbiter #(.ADDR_W(8), .DEPTH(DEPTH_T), .WP_LO(WP_LO_T), .WP_HI(WP_HI_T)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack), .o_a_rdata(a_rdata), .o_a_ovf(a_ovf),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack), .o_b_rdata(b_rdata), .o_b_ovf(b_ovf),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_wp_err(wp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with one clock read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (a_ack && a_n < 64) begin a_d[a_n] <= a_rdata; a_t[a_n] <= cyc; a_n <= a_n + 1; end
    if (b_ack && b_n < 64) begin b_d[b_n] <= b_rdata; b_t[b_n] <= cyc; b_n <= b_n + 1; end
    if (ram_en && rl_n < 64) begin
      rl_t[rl_n] <= cyc; rl_we[rl_n] <= ram_we; rl_ad[rl_n] <= ram_addr; rl_wd[rl_n] <= ram_wdata;
      rl_n <= rl_n + 1;
    end
    if (wp_err) wp_n <= wp_n + 1;
  end

  task automatic push_exp(input bit is_b, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                          input int t, input int lat);
    sb_t e;
    e.we = we; e.t = t; e.lat = lat; e.exp = 8'h00;
    if (int'(addr) >= DEPTH_T) begin
      if (!we) e.exp = 8'hFF;
    end else if (we) begin
      if (!(is_b && WP_ON && addr >= WP_LO_T && addr <= WP_HI_T)) mdl[addr] = wd;
    end else begin
      e.exp = mdl[addr];
    end
    if (is_b) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic issue(input bit pa, input bit pb, input logic wa, input logic wb,
                       input logic [7:0] ada, input logic [7:0] adb,
                       input logic [7:0] wda, input logic [7:0] wdb, input int la, input int lb);
    @(negedge clk);
    a_req = pa; a_we = wa; a_addr = ada; a_wdata = wda;
    b_req = pb; b_we = wb; b_addr = adb; b_wdata = wdb;
    if (pa) push_exp(1'b0, wa, ada, wda, cyc + 1, la);
    if (pb) push_exp(1'b1, wb, adb, wdb, cyc + 1, lb);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    a_we = 1'($urandom); a_addr = 8'($urandom); a_wdata = 8'($urandom);
    b_we = 1'($urandom); b_addr = 8'($urandom); b_wdata = 8'($urandom);
  endtask

  task automatic wait_a(output bit got, output logic [7:0] d, output int t);
    got = 1'b0; d = 8'h00; t = 0;
    for (int i = 0; i < 64; i++) begin
      if (a_n > ra) begin got = 1'b1; break; end
      @(posedge clk);
    end
    if (got) begin d = a_d[ra]; t = a_t[ra]; ra++; end
  endtask

  task automatic wait_b(output bit got, output logic [7:0] d, output int t);
    got = 1'b0; d = 8'h00; t = 0;
    for (int i = 0; i < 64; i++) begin
      if (b_n > rb) begin got = 1'b1; break; end
      @(posedge clk);
    end
    if (got) begin d = b_d[rb]; t = b_t[rb]; rb++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    ra = a_n; rb = b_n;
    qa.delete(); qb.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ack, b_ack, ram_en, ram_we, wp_err} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b, required 00000", {a_ack, b_ack, ram_en, ram_we, wp_err});
    end
    checks++;
    if ({a_ovf, b_ovf} !== 2'b00) begin
      errors++; $display("FAIL reset_ovf: got %b, required 00", {a_ovf, b_ovf});
    end
    checks++;
    if ({a_rdata, b_rdata} !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h, required 0000", {a_rdata, b_rdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_a();
    bit got; logic [7:0] d; int t; sb_t e; int r0;
    r0 = rl_n;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 8'h00, 3, 0);
    wait_a(got, d, t);
    e = qa.pop_front();
    checks++;
    if (!got || t - e.t != e.lat) begin
      errors++; $display("FAIL wr_a_lat: got %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
    checks++;
    if (rl_n != r0 + 1 || rl_t[r0] - e.t != 2 || rl_we[r0] !== 1'b1 || rl_ad[r0] !== 8'h10 || rl_wd[r0] !== 8'h5A) begin
      errors++;
      $display("FAIL wr_a_ram: got n=%0d t=+%0d we=%b addr=%h data=%h, required n=1 t=+2 we=1 addr=10 data=5a",
               rl_n - r0, rl_t[r0] - e.t, rl_we[r0], rl_ad[r0], rl_wd[r0]);
    end
  endtask

  task automatic test_read_b();
    bit got; logic [7:0] d; int t; sb_t e; int r0;
    r0 = rl_n;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00, 8'h00, 0, 4);
    wait_b(got, d, t);
    e = qb.pop_front();
    checks++;
    if (!got || t - e.t != e.lat || d !== e.exp) begin
      errors++; $display("FAIL rd_b: got lat %0d data %h (ack=%0b), required lat %0d data %h", t - e.t, d, got, e.lat, e.exp);
    end
    checks++;
    if (rl_n != r0 + 1 || rl_we[r0] !== 1'b0 || rl_ad[r0] !== 8'h10) begin
      errors++; $display("FAIL rd_b_ram: got n=%0d we=%b addr=%h, required n=1 we=0 addr=10", rl_n - r0, rl_we[r0], rl_ad[r0]);
    end
    @(negedge clk);
    checks++;
    if (a_rdata !== 8'h00) begin
      errors++; $display("FAIL rd_b_a_rdata_held: got %h, required 00", a_rdata);
    end
  endtask

  task automatic test_arbitration();
    bit got; logic [7:0] d; int t; sb_t e;
    do_reset();
    // Fresh reset: A wins, B waits one full write access.
    issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h21, 8'h11, 8'h22, 3, 6);
    wait_a(got, d, t); e = qa.pop_front();
    checks++;
    if (!got || t - e.t != e.lat) begin
      errors++; $display("FAIL arb1_a_lat: got %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
    wait_b(got, d, t); e = qb.pop_front();
    checks++;
    if (!got || t - e.t != e.lat) begin
      errors++; $display("FAIL arb1_b_lat: got %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 4, 0);
    wait_a(got, d, t); e = qa.pop_front();
    checks++;
    if (!got || t - e.t != e.lat || d !== e.exp) begin
      errors++; $display("FAIL arb_rd_a: got lat %0d data %h (ack=%0b), required lat %0d data %h", t - e.t, d, got, e.lat, e.exp);
    end
    // Last grant went to A, so B now has priority.
    issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h23, 8'h33, 8'h44, 6, 3);
    wait_b(got, d, t); e = qb.pop_front();
    checks++;
    if (!got || t - e.t != e.lat) begin
      errors++; $display("FAIL arb2_b_lat: got %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
    wait_a(got, d, t); e = qa.pop_front();
    checks++;
    if (!got || t - e.t != e.lat) begin
      errors++; $display("FAIL arb2_a_lat: got %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
  endtask

  task automatic test_overflow();
    bit got; logic [7:0] d; int t; sb_t e; int r0;
    r0 = rl_n;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 8'hAA, 8'h00, 3, 0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h31; a_wdata = 8'hBB;
    @(negedge clk);
    a_req = 1'b0;
    wait_a(got, d, t); e = qa.pop_front();
    checks++;
    if (!got || t - e.t != e.lat) begin
      errors++; $display("FAIL ovf_a_lat: got %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (a_n != ra) begin
      errors++; $display("FAIL ovf_single_ack: got %0d extra acks, required 0", a_n - ra);
    end
    checks++;
    if (rl_n != r0 + 1 || rl_ad[r0] !== 8'h30 || rl_wd[r0] !== 8'hAA) begin
      errors++; $display("FAIL ovf_ram: got n=%0d addr=%h data=%h, required n=1 addr=30 data=aa", rl_n - r0, rl_ad[r0], rl_wd[r0]);
    end
    checks++;
    if ({a_ovf, b_ovf} !== 2'b10) begin
      errors++; $display("FAIL ovf_sticky: got %b, required 10", {a_ovf, b_ovf});
    end
    do_reset();
    checks++;
    if (a_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_reset_clear: got %b, required 0", a_ovf);
    end
  endtask

  task automatic test_out_of_range();
    bit got; logic [7:0] d; int t; sb_t e; int r0;
    r0 = rl_n;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 8'h00, 8'h00, 0, 4);
    wait_b(got, d, t); e = qb.pop_front();
    checks++;
    if (!got || t - e.t != e.lat || d !== e.exp) begin
      errors++; $display("FAIL oor_rd_b: got lat %0d data %h (ack=%0b), required lat %0d data %h", t - e.t, d, got, e.lat, e.exp);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h80, 8'h00, 8'h12, 0, 3);
    wait_b(got, d, t); e = qb.pop_front();
    checks++;
    if (!got || t - e.t != e.lat) begin
      errors++; $display("FAIL oor_wr_b_lat: got %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
    checks++;
    if (rl_n != r0) begin
      errors++; $display("FAIL oor_no_strobe: got %0d strobes, required 0", rl_n - r0);
    end
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h00, 8'h77, 8'h00, 3, 0);
    wait_a(got, d, t); e = qa.pop_front();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h00, 8'h00, 8'h00, 4, 0);
    wait_a(got, d, t); e = qa.pop_front();
    checks++;
    if (!got || t - e.t != e.lat || d !== e.exp) begin
      errors++; $display("FAIL last_addr_rd_a: got lat %0d data %h (ack=%0b), required lat %0d data %h", t - e.t, d, got, e.lat, e.exp);
    end
  endtask

  task automatic test_write_protect();
    bit got; logic [7:0] d; int t; sb_t e; int r0; int w0;
    r0 = rl_n; w0 = wp_n;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h74, 8'h00, 8'h6D, 8'h00, 3, 0);
    wait_a(got, d, t); e = qa.pop_front();
    checks++;
    if (!got || rl_n != r0 + 1 || rl_wd[r0] !== 8'h6D || wp_n != w0) begin
      errors++; $display("FAIL wp_a_write: got ack=%0b strobes=%0d data=%h wp=%0d, required ack=1 strobes=1 data=6d wp=0",
                         got, rl_n - r0, rl_wd[r0], wp_n - w0);
    end
    r0 = rl_n; w0 = wp_n;
    issue(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h74, 8'h00, 8'h5C, 0, 3);
    wait_b(got, d, t); e = qb.pop_front();
    checks++;
    if (!got || t - e.t != e.lat || rl_n - r0 != (WP_ON ? 0 : 1) || wp_n - w0 != (WP_ON ? 1 : 0)) begin
      errors++; $display("FAIL wp_b_write: got ack=%0b lat=%0d strobes=%0d wp=%0d, required ack=1 lat=3 strobes=%0d wp=%0d",
                         got, t - e.t, rl_n - r0, wp_n - w0, WP_ON ? 0 : 1, WP_ON ? 1 : 0);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h74, 8'h00, 8'h00, 0, 4);
    wait_b(got, d, t); e = qb.pop_front();
    checks++;
    if (!got || d !== e.exp) begin
      errors++; $display("FAIL wp_b_readback: got %h (ack=%0b), required %h", d, got, e.exp);
    end
  endtask

  task automatic test_back_to_back();
    bit got; bit seen; logic [7:0] d; int t; sb_t e;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 8'h01, 8'h00, 3, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ack) begin seen = 1'b1; break; end
    end
    if (seen) begin
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h40;
      push_exp(1'b0, 1'b0, 8'h40, 8'h00, cyc + 1, 4);
      @(negedge clk);
      a_req = 1'b0;
    end
    wait_a(got, d, t); e = qa.pop_front();
    checks++;
    if (!seen || !got || t - e.t != e.lat) begin
      errors++; $display("FAIL b2b_wr_a: got lat %0d (ack=%0b), required %0d", t - e.t, got, e.lat);
    end
    if (seen) begin
      wait_a(got, d, t); e = qa.pop_front();
      checks++;
      if (!got || t - e.t != e.lat || d !== e.exp) begin
        errors++; $display("FAIL b2b_rd_a: got lat %0d data %h (ack=%0b), required lat %0d data %h", t - e.t, d, got, e.lat, e.exp);
      end
    end
    @(negedge clk);
    checks++;
    if (a_ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_no_ovf: got %b, required 0", a_ovf);
    end
  endtask

  task automatic test_reset_mid_access();
    int r0; int a0;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 4, 0);
    void'(qa.pop_back());
    rst_n = 1'b0;
    @(posedge clk);
    r0 = rl_n; a0 = a_n;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (rl_n != r0 || a_n != a0) begin
      errors++; $display("FAIL reset_abort: got strobes=%0d acks=%0d, required 0 and 0", rl_n - r0, a_n - a0);
    end
    ra = a_n; rb = b_n;
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_arbitration();
    test_overflow();
    test_out_of_range();
    test_write_protect();
    test_back_to_back();
    test_reset_mid_access();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
